// File: rtl/vga_timing.sv
// 640x480@60 Hz raster timing: pixel-rate prescaler, h/v scan counters, registered
// negative-polarity syncs, blanked colour outputs and a one-clk end-of-frame pulse.
module vga_timing #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rgb_in,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       pix_tick,
   output logic       video_on,
   output logic       frame_tick,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] vgaRed,
   output logic [2:0] vgaGreen,
   output logic [1:0] vgaBlue
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int PRE_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ARM  = PRE_W'(CLK_DIV - 2);

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   function automatic logic in_window(input logic [9:0] cnt,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
      return (cnt >= lo) && (cnt < hi);
   endfunction

   logic [PRE_W-1:0] prescaler;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic             line_end;
   logic             frame_end;
   logic             tick_arm;
   logic             active;

   assign line_end  = (h_cnt == H_LAST);
   assign frame_end = line_end && (v_cnt == V_LAST);
   assign tick_arm  = (prescaler == PRE_ARM);
   assign active    = (h_cnt < H_VIS) && (v_cnt < V_VIS);

   assign pix_x = h_cnt;
   assign pix_y = v_cnt;

   // Stage 0: prescaler; pix_tick/frame_tick are armed one clk early so they
   // are high in the clk where prescaler sits at CLK_DIV-1.
   always_ff @(posedge clk) begin
      if (!rst) begin
         prescaler  <= '0;
         pix_tick   <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         prescaler  <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
         pix_tick   <= tick_arm;
         frame_tick <= tick_arm && frame_end;
      end
   end

   // Stage 1: scan counters advance on the edge that closes a pix_tick clk
   always_ff @(posedge clk) begin
      if (!rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_tick) begin
         if (line_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   // Stage 2: decoded syncs and blanked colour, one clk behind pix_x/pix_y
   always_ff @(posedge clk) begin
      if (!rst) begin
         hsync    <= 1'b1;
         vsync    <= 1'b1;
         video_on <= 1'b0;
         vgaRed   <= '0;
         vgaGreen <= '0;
         vgaBlue  <= '0;
      end else begin
         hsync    <= ~in_window(h_cnt, HS_START, HS_END);
         vsync    <= ~in_window(v_cnt, VS_START, VS_END);
         video_on <= active;
         {vgaRed, vgaGreen, vgaBlue} <= active ? rgb_in : 8'd0;
      end
   end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size instance for line timing and colour, reduced
// instance (H 8/2/2/2, V 6/1/1/1, CLK_DIV 2) for frame-level behaviour.
module tb_vga_timing;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b;
   logic [7:0] rgb_a, rgb_b;
   logic [9:0] pix_x_a, pix_y_a, pix_x_b, pix_y_b;
   logic       pix_tick_a, video_on_a, frame_tick_a, hsync_a, vsync_a;
   logic       pix_tick_b, video_on_b, frame_tick_b, hsync_b, vsync_b;
   logic [2:0] red_a, green_a, red_b, green_b;
   logic [1:0] blue_a, blue_b;

   vga_timing dut_a (
      .clk(clk), .rst(rst_a), .rgb_in(rgb_a),
      .pix_x(pix_x_a), .pix_y(pix_y_a), .pix_tick(pix_tick_a),
      .video_on(video_on_a), .frame_tick(frame_tick_a),
      .hsync(hsync_a), .vsync(vsync_a),
      .vgaRed(red_a), .vgaGreen(green_a), .vgaBlue(blue_a)
   );

   vga_timing #(
      .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut_b (
      .clk(clk), .rst(rst_b), .rgb_in(rgb_b),
      .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_tick(pix_tick_b),
      .video_on(video_on_b), .frame_tick(frame_tick_b),
      .hsync(hsync_b), .vsync(vsync_b),
      .vgaRed(red_b), .vgaGreen(green_b), .vgaBlue(blue_b)
   );

   typedef struct {
      int x;
      int y;
      int rgb;
      int exp_rgb;
      int exp_von;
      int exp_hs;
      int exp_vs;
   } vec_t;

   vec_t vecs[11];
   int   total  = 0;
   int   passed = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_a(input int x, input int y, input int budget, input string name);
      int  n;
      bit  ok;
      n  = 0;
      ok = 1'b0;
      while (n < budget && !ok) begin
         step();
         n++;
         if (int'(pix_x_a) == x && (y < 0 || int'(pix_y_a) == y)) ok = 1'b1;
      end
      if (!ok) check({"timeout ", name}, 0, 1);
   endtask

   task automatic wait_b(input int x, input int y, input int budget, input string name);
      int  n;
      bit  ok;
      n  = 0;
      ok = 1'b0;
      while (n < budget && !ok) begin
         step();
         n++;
         if (int'(pix_x_b) == x && int'(pix_y_b) == y) ok = 1'b1;
      end
      if (!ok) check({"timeout ", name}, 0, 1);
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, " pix_x"},    int'(pix_x_a), 0);
      check({tag, " pix_y"},    int'(pix_y_a), 0);
      check({tag, " hsync"},    int'(hsync_a), 1);
      check({tag, " vsync"},    int'(vsync_a), 1);
      check({tag, " colour"},   int'({red_a, green_a, blue_a}), 0);
      check({tag, " video_on"}, int'(video_on_a), 0);
      check({tag, " pix_tick"}, int'(pix_tick_a), 0);
   endtask

   initial begin
      int n, y0, low, ft_bad, ft_cnt;

      vecs[0]  = '{0,  0, 'hA5, 'hA5, 1, 1, 1};
      vecs[1]  = '{7,  0, 'h3C, 'h3C, 1, 1, 1};
      vecs[2]  = '{8,  0, 'hFF, 'h00, 0, 1, 1};
      vecs[3]  = '{10, 1, 'hFF, 'h00, 0, 0, 1};
      vecs[4]  = '{11, 2, 'h5A, 'h00, 0, 0, 1};
      vecs[5]  = '{12, 2, 'hFF, 'h00, 0, 1, 1};
      vecs[6]  = '{7,  5, 'hFF, 'hFF, 1, 1, 1};
      vecs[7]  = '{0,  6, 'hFF, 'h00, 0, 1, 1};
      vecs[8]  = '{3,  7, 'hFF, 'h00, 0, 1, 0};
      vecs[9]  = '{10, 7, 'hFF, 'h00, 0, 0, 0};
      vecs[10] = '{13, 8, 'h12, 'h00, 0, 1, 1};

      rst_a = 1'b0;
      rst_b = 1'b0;
      rgb_a = 8'h00;
      rgb_b = 8'h00;

      // reset held for 5 clks
      repeat (5) step();
      check_reset_a("reset");
      check("reset frame_tick", int'(frame_tick_a), 0);
      check("reset b hsync", int'(hsync_b), 1);
      check("reset b pix_x", int'(pix_x_b), 0);

      // release: first pix_tick in the 4th clk, pix_x=1 after it
      rst_a = 1'b1;
      step(); check("tick clk1", int'(pix_tick_a), 0);
      step(); check("tick clk2", int'(pix_tick_a), 0);
      step(); check("tick clk3", int'(pix_tick_a), 1);
      check("pix_x before tick", int'(pix_x_a), 0);
      step(); check("tick clk4 off", int'(pix_tick_a), 0);
      check("pix_x after tick", int'(pix_x_a), 1);
      repeat (3) step();
      check("second tick", int'(pix_tick_a), 1);

      // reduced instance: table of positions across one frame
      rst_b = 1'b1;
      for (int i = 0; i < 11; i++) begin
         wait_b(vecs[i].x, vecs[i].y, 600, $sformatf("vec%0d", i));
         rgb_b = 8'(vecs[i].rgb);
         step();
         check($sformatf("vec%0d colour", i), int'({red_b, green_b, blue_b}), vecs[i].exp_rgb);
         check($sformatf("vec%0d video_on", i), int'(video_on_b), vecs[i].exp_von);
         check($sformatf("vec%0d hsync", i), int'(hsync_b), vecs[i].exp_hs);
         check($sformatf("vec%0d vsync", i), int'(vsync_b), vecs[i].exp_vs);
      end

      // reduced instance: frame period, frame_tick position, vsync width
      n = 0;
      while (frame_tick_b == 1'b0 && n < 600) begin step(); n++; end
      check("frame_tick found", int'(frame_tick_b), 1);
      check("frame_tick pix_tick", int'(pix_tick_b), 1);
      check("frame_tick pix_x", int'(pix_x_b), 13);
      check("frame_tick pix_y", int'(pix_y_b), 8);
      n = 0; low = 0; ft_bad = 0; ft_cnt = 0;
      do begin
         step();
         n++;
         if (vsync_b == 1'b0) low++;
         if (frame_tick_b && !pix_tick_b) ft_bad++;
         if (frame_tick_b) ft_cnt++;
      end while (frame_tick_b == 1'b0 && n < 600);
      check("frame period", n, 252);
      check("frame ticks per frame", ft_cnt, 1);
      check("frame_tick without pix_tick", ft_bad, 0);
      check("vsync low clks", low, 28);

      // full-size line: hsync window and width
      wait_a(655, -1, 4000, "x655");
      wait_a(656, -1, 8, "x656");
      check("hsync at x656", int'(hsync_a), 1);
      step();
      check("hsync low start", int'(hsync_a), 0);
      low = 0;
      while (hsync_a == 1'b0 && low < 1000) begin low++; step(); end
      check("hsync low clks", low, 384);

      wait_a(799, -1, 1000, "x799");
      y0 = int'(pix_y_a);
      check("y before wrap", y0, 0);
      wait_a(0, -1, 8, "x wrap");
      check("y after wrap", int'(pix_y_a), 1);
      n = 0;
      do begin step(); n++; end while (pix_x_a == 10'd0 && n < 8);
      while (pix_x_a != 10'd0 && n < 4000) begin step(); n++; end
      check("line period", n, 3200);

      // horizontal blanking edge with constant white
      rgb_a = 8'hFF;
      wait_a(639, -1, 4000, "x639");
      wait_a(640, -1, 8, "x640");
      check("x639 colour", int'({red_a, green_a, blue_a}), 'hFF);
      check("x639 video_on", int'(video_on_a), 1);
      step();
      check("x640 colour", int'({red_a, green_a, blue_a}), 0);
      check("x640 video_on", int'(video_on_a), 0);

      // colour pass-through at (5,3)
      wait_a(5, 3, 4000, "pos 5,3");
      rgb_a = 8'b101_010_01;
      step();
      check("pass red", int'(red_a), 5);
      check("pass green", int'(green_a), 2);
      check("pass blue", int'(blue_a), 1);

      // mid-line reset on the full-size instance
      wait_a(300, 3, 2000, "pos 300,3");
      rst_a = 1'b0;
      step();
      rst_a = 1'b1;
      check_reset_a("midreset");
      step(); check("midreset tick1", int'(pix_tick_a), 0);
      step(); check("midreset tick2", int'(pix_tick_a), 0);
      step(); check("midreset tick3", int'(pix_tick_a), 1);

      // mid-frame reset on the reduced instance: full frame before frame_tick
      rgb_b = 8'hFF;
      wait_b(5, 3, 600, "b pos 5,3");
      rst_b = 1'b0;
      step();
      rst_b = 1'b1;
      check("b midreset pix_x", int'(pix_x_b), 0);
      check("b midreset pix_y", int'(pix_y_b), 0);
      check("b midreset colour", int'({red_b, green_b, blue_b}), 0);
      check("b midreset video_on", int'(video_on_b), 0);
      check("b midreset frame_tick", int'(frame_tick_b), 0);
      n = 0;
      while (frame_tick_b == 1'b0 && n < 600) begin step(); n++; end
      check("b clks to first frame_tick", n, 251);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
